// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the encoder and receiver sides.
// Patterns are 7 bits with segment a at the LSB, 1 = lit.
package seg7_pkg;

    localparam int FRAME_BITS = 8;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } rx_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse of the decimal seven-segment table: pattern -> {hit, digit}.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic             hit,
    output logic [3:0]       digit
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hit   = 1'b1;
        digit = DIGIT_INVALID;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_serial_rx.sv
// Serial 8-bit frame receiver: deserialises segments + carry, decodes the digit,
// and drops partial frames after TIMEOUT_CYCLES strobe-free cycles.
module seg7_serial_rx
    import seg7_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    input  logic       ser_en,
    output logic [3:0] digit,
    output logic       carry,
    output logic       valid,
    output logic       err,
    output logic       busy
);

    localparam int                CNT_W     = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);
    localparam logic [7:0]        IDLE_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       idle_cnt_q, idle_cnt_d;
    logic [SEG_W-1:0] shift_q, shift_d;
    logic [3:0]       digit_q, digit_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    rx_state_e        state;
    logic [SEG_W-1:0] seg_pattern;
    logic             dec_hit;
    logic [3:0]       dec_digit;

    // By the last bit's edge all seven segment bits already sit in the shift register.
    assign seg_pattern = shift_q ^ {SEG_W{SEG_ACTIVE_LOW}};

    seg7_pattern_decode u_decode (
        .pattern (seg_pattern),
        .hit     (dec_hit),
        .digit   (dec_digit)
    );

    always_comb begin
        state      = (bit_cnt_q == '0) ? ST_IDLE : ST_SHIFT;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        shift_d    = shift_q;
        digit_d    = digit_q;
        carry_d    = carry_q;
        err_d      = err_q;
        valid_d    = 1'b0;

        if (ser_en) begin
            idle_cnt_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
                digit_d   = dec_digit;
                err_d     = ~dec_hit;
                carry_d   = ser_in;
                valid_d   = 1'b1;
                bit_cnt_d = '0;
                shift_d   = '0;
            end else begin
                shift_d[bit_cnt_q] = ser_in;
                bit_cnt_d          = bit_cnt_q + 1'b1;
            end
        end else if (state == ST_SHIFT) begin
            // Reaching the limit on this edge drops the partial frame; outputs untouched.
            if (idle_cnt_q >= IDLE_LAST) begin
                bit_cnt_d  = '0;
                idle_cnt_d = '0;
                shift_d    = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 8'd1;
            end
        end else begin
            idle_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            shift_q    <= '0;
            digit_q    <= '0;
            carry_q    <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            shift_q    <= shift_d;
            digit_q    <= digit_d;
            carry_q    <= carry_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign digit = digit_q;
    assign carry = carry_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (bit_cnt_q != '0);

endmodule
